// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and port ids for the dmem arbiter
package dmem_arb_pkg;
  typedef logic arb_id_t;
  typedef struct packed {
    logic    valid;
    arb_id_t id;
  } tag_t;
  localparam arb_id_t PORT_CORE = 1'b0;
  localparam arb_id_t PORT_DBG  = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-port round-robin grant logic with the last-grant flop
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       hold_in,
  input  logic [1:0] valid_in,
  output logic [1:0] grant_out,
  output logic       grant_any_out,
  output arb_id_t    grant_id_out
);
  arb_id_t r_last;
  // on a conflict the port that did not win last time goes first
  always_comb begin
    grant_out = hold_in ? 2'b00 : (&valid_in) ? ((r_last == PORT_DBG) ? 2'b01 : 2'b10) : valid_in;
  end
  assign grant_any_out = |grant_out;
  assign grant_id_out  = grant_out[1] ? PORT_DBG : PORT_CORE;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_last <= PORT_DBG;
    else if (grant_any_out) r_last <= grant_id_out;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one BRAM port between core and loader, tagged read returns.
// Defining DMEM_ARB_STATS_EN adds per-port accept counters and a conflict counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              hold_in,
  input  logic [1:0]        req_valid_in,
  output logic [1:0]        req_ready_out,
  input  logic [1:0][31:0]  req_addr_in,
  input  logic [1:0][31:0]  req_wdata_in,
  input  logic [1:0][3:0]   req_wstrb_in,
  output logic [1:0]        rsp_valid_out,
  output logic [31:0]       rsp_data_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [31:0]       mem_din_out,
  output logic [3:0]        mem_we_out,
  output logic              mem_en_out,
  input  logic [31:0]       mem_dout_in
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [1:0][31:0]  grant_cnt_out,
  output logic [31:0]       conflict_cnt_out
`endif
);
  logic       w_grant_any;
  arb_id_t    w_grant_id;
  tag_t       r_tag [LATENCY];
  logic [1:0] r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic       w_unused;

  rr_arbiter2 u_arb (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .hold_in       (hold_in),
    .valid_in      (req_valid_in),
    .grant_out     (req_ready_out),
    .grant_any_out (w_grant_any),
    .grant_id_out  (w_grant_id)
  );

  // with no grant the id is PORT_CORE, so addr/din idle on the port-0 request
  assign mem_en_out   = w_grant_any;
  assign mem_addr_out = req_addr_in[w_grant_id][ADDR_W+1:2];
  assign mem_din_out  = req_wdata_in[w_grant_id];
  assign mem_we_out   = w_grant_any ? req_wstrb_in[w_grant_id] : 4'b0000;
  assign w_unused     = ^{req_addr_in[0][31:ADDR_W+2], req_addr_in[0][1:0],
                          req_addr_in[1][31:ADDR_W+2], req_addr_in[1][1:0]};

  // the tag reaches the last stage in the cycle the BRAM presents the word
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_tag[0] <= tag_t'{valid: w_grant_any, id: w_grant_id};
      for (int i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
      r_rsp_valid <= r_tag[LATENCY-1].valid ? ((r_tag[LATENCY-1].id == PORT_DBG) ? 2'b10 : 2'b01) : 2'b00;
      r_rsp_data  <= r_tag[LATENCY-1].valid ? mem_dout_in : 32'h0;
    end
  end

  assign rsp_valid_out = r_rsp_valid;
  assign rsp_data_out  = r_rsp_data;

`ifdef DMEM_ARB_STATS_EN
  logic [1:0][31:0] r_grant_cnt;
  logic [31:0]      r_conflict_cnt;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_grant_cnt    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (req_ready_out[0]) r_grant_cnt[0] <= r_grant_cnt[0] + 32'd1;
      if (req_ready_out[1]) r_grant_cnt[1] <= r_grant_cnt[1] + 32'd1;
      if ((&req_valid_in) && !hold_in) r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end
  assign grant_cnt_out    = r_grant_cnt;
  assign conflict_cnt_out = r_conflict_cnt;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed checks of dmem_arbiter against a queue-based response model
module tb_dmem_arbiter;
  localparam int AW  = 14;
  localparam int LAT = 2;

  typedef struct {
    int          due;
    logic        id;
    logic [31:0] d;
  } exp_t;

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b0;
  logic             hold_in = 1'b0;
  logic [1:0]       req_valid_in = '0;
  logic [1:0]       req_ready_out;
  logic [1:0][31:0] req_addr_in = '0;
  logic [1:0][31:0] req_wdata_in = '0;
  logic [1:0][3:0]  req_wstrb_in = '0;
  logic [1:0]       rsp_valid_out;
  logic [31:0]      rsp_data_out;
  logic [AW-1:0]    mem_addr_out;
  logic [31:0]      mem_din_out;
  logic [3:0]       mem_we_out;
  logic             mem_en_out;
  logic [31:0]      mem_dout_in;
`ifdef DMEM_ARB_STATS_EN
  logic [1:0][31:0] grant_cnt_out;
  logic [31:0]      conflict_cnt_out;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rc0 = 0;
  int rc1 = 0;
  logic m_last = 1'b1;
  exp_t q[$];
  logic [31:0] bram [0:(1<<AW)-1];
  logic [31:0] mm [0:(1<<AW)-1];
  logic [31:0] r_lat;
  logic [31:0] r_o [LAT];

  dmem_arbiter #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .hold_in       (hold_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_addr_in   (req_addr_in),
    .req_wdata_in  (req_wdata_in),
    .req_wstrb_in  (req_wstrb_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_data_out  (rsp_data_out),
    .mem_addr_out  (mem_addr_out),
    .mem_din_out   (mem_din_out),
    .mem_we_out    (mem_we_out),
    .mem_en_out    (mem_en_out),
    .mem_dout_in   (mem_dout_in)
`ifdef DMEM_ARB_STATS_EN
    ,
    .grant_cnt_out    (grant_cnt_out),
    .conflict_cnt_out (conflict_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // read-first BRAM: array read latches only when enabled, output register always advances
  always @(posedge clk_in) begin
    if (mem_en_out) begin
      r_lat <= bram[mem_addr_out];
      for (int b = 0; b < 4; b++)
        if (mem_we_out[b]) bram[mem_addr_out][8*b +: 8] <= mem_din_out[8*b +: 8];
    end
    r_o[0] <= r_lat;
    for (int i = 1; i < LAT; i++) r_o[i] <= r_o[i-1];
  end
  assign mem_dout_in = (LAT == 1) ? r_lat : r_o[LAT-2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference: grants from the round-robin rule, responses from a queue of accepted requests
  always @(negedge clk_in) begin
    logic [1:0] g;
    logic       s;
    logic [AW-1:0] wa;
    exp_t e;
    cyc++;
    if (rsp_valid_out[0]) rc0++;
    if (rsp_valid_out[1]) rc1++;
    if (!rst_n_in) begin
      q.delete();
      m_last = 1'b1;
      chk("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
      chk("rst_rsp_data", rsp_data_out, 32'd0);
    end else begin
      g = hold_in ? 2'b00 : (req_valid_in == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req_valid_in;
      s = g[1];
      chk("ready", 32'(req_ready_out), 32'(g));
      chk("mem_en", 32'(mem_en_out), 32'(g != 2'b00));
      chk("mem_we", 32'(mem_we_out), (g != 2'b00) ? 32'(req_wstrb_in[s]) : 32'd0);
      chk("mem_addr", 32'(mem_addr_out), 32'(req_addr_in[s][AW+1:2]));
      chk("mem_din", mem_din_out, req_wdata_in[s]);
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp_valid", 32'(rsp_valid_out), e.id ? 32'd2 : 32'd1);
        chk("rsp_data", rsp_data_out, e.d);
      end else begin
        chk("rsp_idle_valid", 32'(rsp_valid_out), 32'd0);
        chk("rsp_idle_data", rsp_data_out, 32'd0);
      end
      if (g != 2'b00) begin
        wa = req_addr_in[s][AW+1:2];
        e.d = mm[wa];
        for (int b = 0; b < 4; b++)
          if (req_wstrb_in[s][b]) mm[wa][8*b +: 8] = req_wdata_in[s][8*b +: 8];
        e.id = s;
        e.due = cyc + LAT + 1;
        q.push_back(e);
        m_last = s;
      end
    end
  end

  task automatic idle();
    req_valid_in = '0;
    hold_in = 1'b0;
    req_wstrb_in = '0;
  endtask

  task automatic drive(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid_in[p] = 1'b1;
    req_addr_in[p]  = a;
    req_wdata_in[p] = d;
    req_wstrb_in[p] = s;
  endtask

  task automatic single_read();
    @(posedge clk_in); #1;
    idle();
    drive(0, 32'h0000_0010, 32'h0, 4'b0000);
    @(negedge clk_in);
    chk("sr_ready", 32'(req_ready_out), 32'd1);
    chk("sr_addr", 32'(mem_addr_out), 32'd4);
    @(posedge clk_in); #1;
    idle();
    repeat (LAT) @(posedge clk_in);
    @(negedge clk_in);
    chk("sr_rsp_valid", 32'(rsp_valid_out), 32'd1);
    chk("sr_rsp_data", rsp_data_out, 32'hDEADBEEF);
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < (1 << AW); i++) begin
      bram[i] = $urandom;
      mm[i] = bram[i];
    end
    bram[4] = 32'hDEADBEEF; mm[4] = 32'hDEADBEEF;
    bram[8] = 32'hAAAAAAAA; mm[8] = 32'hAAAAAAAA;
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    // conflict fairness from reset: 0,1,0,1,0,1
    @(posedge clk_in); #1;
    rc0 = 0; rc1 = 0;
    for (int k = 0; k < 6; k++) begin
      idle();
      drive(0, 32'((40 + k) * 4), 32'h0, 4'b0000);
      drive(1, 32'((60 + k) * 4), 32'h0, 4'b0000);
      @(negedge clk_in);
      chk("conflict_ready", 32'(req_ready_out), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk_in); #1;
    end
    idle();
    repeat (LAT + 2) @(posedge clk_in);
    @(negedge clk_in);
    chk("conflict_rsp0", 32'(rc0), 32'd3);
    chk("conflict_rsp1", 32'(rc1), 32'd3);
`ifdef DMEM_ARB_STATS_EN
    chk("stats_grant0", grant_cnt_out[0], 32'd3);
    chk("stats_grant1", grant_cnt_out[1], 32'd3);
    chk("stats_conflict", conflict_cnt_out, 32'd6);
`endif

    single_read();

    // partial write then read-back of word 8
    @(posedge clk_in); #1;
    idle();
    drive(1, 32'h0000_0020, 32'h12345678, 4'b0011);
    @(posedge clk_in); #1;
    idle();
    drive(1, 32'h0000_0020, 32'h0, 4'b0000);
    @(posedge clk_in); #1;
    idle();
    @(posedge clk_in);
    @(negedge clk_in);
    chk("wr_rsp_valid", 32'(rsp_valid_out), 32'd2);
    chk("wr_rsp_data", rsp_data_out, 32'hAAAAAAAA);
    @(posedge clk_in);
    @(negedge clk_in);
    chk("rd_after_wr", rsp_data_out, 32'hAAAA5678);

    // hold with two reads in flight
    @(posedge clk_in); #1;
    idle();
    drive(0, 32'h0000_0010, 32'h0, 4'b0000);
    @(posedge clk_in); #1;
    idle();
    drive(1, 32'h0000_0020, 32'h0, 4'b0000);
    @(posedge clk_in); #1;
    drive(0, 32'h0000_0010, 32'h0, 4'b0000);
    hold_in = 1'b1;
    @(negedge clk_in);
    chk("hold_ready", 32'(req_ready_out), 32'd0);
    chk("hold_en", 32'(mem_en_out), 32'd0);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("hold_rsp0", 32'(rsp_valid_out), 32'd1);
    chk("hold_rsp0_data", rsp_data_out, 32'hDEADBEEF);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("hold_rsp1", 32'(rsp_valid_out), 32'd2);
    chk("hold_rsp1_data", rsp_data_out, 32'hAAAA5678);
    @(posedge clk_in); #1;
    hold_in = 1'b0;
    #1 chk("hold_release_ready", 32'(req_ready_out), 32'd1);
    @(posedge clk_in); #1;
    idle();
    repeat (LAT + 3) @(posedge clk_in);

    // reset while two requests are in flight
    #1;
    drive(0, 32'h0000_0010, 32'h0, 4'b0000);
    @(posedge clk_in); #1;
    idle();
    drive(1, 32'h0000_0014, 32'h0, 4'b0000);
    @(posedge clk_in); #1;
    idle();
    @(posedge clk_in); #1;
    chk("pre_reset_rsp", 32'(rsp_valid_out), 32'd1);
    rst_n_in = 1'b0;
    #1 chk("async_reset_rsp", 32'(rsp_valid_out), 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    repeat (5) @(posedge clk_in);
    single_read();

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk_in); #1;
      idle();
      hold_in = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 3) != 0) begin
          a = $urandom;
          a[AW+1:2] = AW'($urandom_range(0, 31));
          drive(p, a, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000);
        end
    end
    @(posedge clk_in); #1;
    idle();
    repeat (LAT + 3) @(posedge clk_in);
    @(negedge clk_in);
    chk("drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
